// File: rtl/uart_tx_bus_if.sv
// rtl/uart_tx_bus_if.sv - picorv32 native bus request signals seen by uart_tx_bus
interface uart_tx_bus_if;
    logic        enable;
    logic        mem_valid;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;

    modport master (output enable, mem_valid, mem_wstrb, mem_wdata, mem_addr);
    modport slave  (input  enable, mem_valid, mem_wstrb, mem_wdata, mem_addr);
endinterface

// File: rtl/uart_tx_bus.sv
// rtl/uart_tx_bus.sv - memory-mapped 8N1 UART transmitter with TX FIFO on the picorv32 bus
module uart_tx_bus #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_bus_if.slave bus,
    output wire          mem_ready,
    output wire  [31:0]  mem_rdata,
    output logic         tx
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(DIV - 1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic              ready_r;
    logic [31:0]       rdata_r;

    logic              full;
    logic              empty;
    logic              busy;
    logic              req;
    logic              is_write;
    logic              is_push;
    logic              push;
    logic              stall;
    logic              pop;
    logic [31:0]       status;

    // Only addr[2], wdata[7:0] and the strobes carry meaning for this peripheral
    wire unused_bus = &{1'b0, bus.mem_addr[31:3], bus.mem_addr[1:0], bus.mem_wdata[31:8]};

    assign full     = (count == COUNT_FULL);
    assign empty    = (count == '0);
    assign busy     = (state != ST_IDLE);
    assign req      = bus.enable & bus.mem_valid & ~ready_r;
    assign is_write = |bus.mem_wstrb;
    assign is_push  = req & ~bus.mem_addr[2] & bus.mem_wstrb[0];
    assign push     = is_push & ~full;
    assign stall    = is_push & full;
    assign pop      = (state == ST_IDLE) & ~empty;
    assign status   = {16'h0, 8'(count), 5'h0, empty, full, busy};

    // Shared bus with the RAM controller: release the outputs whenever not selected
    assign mem_ready = bus.enable ? ready_r : 1'bz;
    assign mem_rdata = bus.enable ? rdata_r : 32'bz;

    // Ack one request per handshake; a DATA write into a full FIFO is retried each cycle until a slot frees
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r <= 1'b0;
            rdata_r <= '0;
        end else begin
            ready_r <= req & ~stall;
            if (req & ~stall) begin
                rdata_r <= (!is_write && bus.mem_addr[2]) ? status : 32'h0;
            end
        end
    end

    // FIFO storage, left unreset since only slots below count are ever read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Serialiser: start, eight data bits LSB first, stop, each DIV clocks; one idle clock between frames
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift <= fifo_mem[rd_ptr];
                        tx    <= 1'b0;
                        cnt   <= CNT_TOP;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == '0) begin
                        tx      <= shift[0];
                        cnt     <= CNT_TOP;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == '0) begin
                        cnt <= CNT_TOP;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            tx      <= shift[1];
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_bus.sv
// tb/tb_uart_tx_bus.sv - self-checking bench for uart_tx_bus
module tb_uart_tx_bus;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int DEPTH  = 4;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int FRAME  = 10 * DIV;

    logic        clk = 1'b0;
    logic        reset;
    wire         mem_ready;
    wire  [31:0] mem_rdata;
    wire         tx;

    uart_tx_bus_if bus_if();

    uart_tx_bus #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .tx(tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_total = 0;
    int          n_pass  = 0;
    int          starts_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    int          push_cnt = 0;
    int          frame_err = 0;
    bit          rx_busy = 1'b0;
    int          rx_tick = 0;
    logic [9:0]  rx_bits = '0;
    logic        tx_at_ready;

    // Line receiver: finds start bits, samples mid-bit, logs frame start cycles and bytes
    always @(negedge clk) begin
        if (reset) begin
            rx_busy <= 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy <= 1'b1;
                rx_tick <= 1;
                rx_bits <= '0;
                starts_q.push_back(cyc);
            end
        end else begin
            if (rx_tick == FRAME - DIV / 2) begin
                if (tx !== 1'b1 || rx_bits[0] !== 1'b0) frame_err <= frame_err + 1;
                rx_q.push_back(rx_bits[8:1]);
                rx_busy <= 1'b0;
            end else if (rx_tick % DIV == DIV / 2) begin
                rx_bits[rx_tick / DIV] <= tx;
            end
            rx_tick <= rx_tick + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Status expected at a request edge: bytes acked minus frames started strictly before it
    function automatic logic [31:0] model_status(input int req_cyc);
        int popped = 0;
        int last   = -1000000;
        int cnt;
        foreach (starts_q[i]) begin
            if (starts_q[i] < req_cyc) begin
                popped++;
                last = starts_q[i];
            end
        end
        cnt = push_cnt - popped;
        return {16'h0, 8'(cnt), 5'h0, cnt == 0, cnt == DEPTH, (req_cyc - last) <= FRAME};
    endfunction

    task automatic xfer(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                        input int budget, output logic [31:0] rdata, output int lat, output int req_cyc);
        bus_if.enable    = 1'b1;
        bus_if.mem_valid = 1'b1;
        bus_if.mem_addr  = addr;
        bus_if.mem_wstrb = wstrb;
        bus_if.mem_wdata = wdata;
        lat = -1;
        rdata = '0;
        req_cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                lat = i;
                rdata = mem_rdata;
                req_cyc = cyc;
                tx_at_ready = tx;
                break;
            end
        end
        bus_if.mem_valid = 1'b0;
        bus_if.mem_wstrb = 4'h0;
        if (lat > 0 && !addr[2] && wstrb[0]) begin
            push_cnt++;
            exp_q.push_back(wdata[7:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_and_compare(input string name);
        int waited = 0;
        int bad = 0;
        while ((rx_q.size() < exp_q.size() || rx_busy) && waited < 12 * (FRAME + 1)) begin
            @(negedge clk);
            waited++;
        end
        idle(DIV + 2);
        check({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        check({name, "_bytes"}, 32'(bad), 32'd0);
        rx_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t        vecs [9];
        logic [31:0] rd;
        int          lat;
        int          rc;
        int          rc2;
        int          s;
        int          base;
        int          bad;
        int          r;
        logic [9:0]  fb;
        logic [3:0]  ws;

        vecs[0] = '{32'h4, 4'h0, 32'h0,        1'b1, 32'h4};
        vecs[1] = '{32'h0, 4'h0, 32'h0,        1'b1, 32'h0};
        vecs[2] = '{32'h4, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[3] = '{32'h0, 4'h2, 32'h0000_AA00, 1'b0, 32'h0};
        vecs[4] = '{32'h4, 4'h0, 32'h0,        1'b1, 32'h4};
        vecs[5] = '{32'hC, 4'h0, 32'h0,        1'b1, 32'h4};
        vecs[6] = '{32'h8, 4'h0, 32'h0,        1'b1, 32'h0};
        vecs[7] = '{32'h0, 4'hE, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[8] = '{32'h1004, 4'h0, 32'h0,     1'b1, 32'h4};

        reset = 1'b1;
        bus_if.enable    = 1'b1;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_wstrb = 4'h0;
        bus_if.mem_wdata = 32'h0;
        bus_if.mem_addr  = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_ready", 32'(mem_ready), 32'd0);
        check("reset_rdata", mem_rdata, 32'h0);

        // Register access table at idle: all acked in one cycle, no pushes
        for (int i = 0; i < 9; i++) begin
            xfer(vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, 10, rd, lat, rc);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end
        idle(FRAME);
        check("vec_no_frames", 32'(starts_q.size()), 32'd0);

        // Single byte 0x55: exact waveform of one frame
        xfer(32'h0, 4'h1, 32'h0000_0055, 10, rd, lat, rc);
        check("t1_lat", 32'(lat), 32'd1);
        check("t1_tx_high_at_ready", 32'(tx_at_ready), 32'd1);
        @(negedge clk);
        check("t1_tx_low_2clk", 32'(tx), 32'd0);
        fb = {1'b1, 8'h55, 1'b0};
        bad = 0;
        for (int t = 0; t < FRAME; t++) begin
            if (tx !== fb[t / DIV]) bad++;
            @(negedge clk);
        end
        check("t1_waveform", 32'(bad), 32'd0);
        check("t1_tx_idle_after", 32'(tx), 32'd1);
        drain_and_compare("t1");

        // Status at idle and while a frame is on the line
        xfer(32'h4, 4'h0, 32'h0, 10, rd, lat, rc);
        check("t2_status_idle", rd, 32'h4);
        xfer(32'h0, 4'h1, 32'h0000_00A3, 10, rd, lat, rc);
        idle(20);
        xfer(32'h4, 4'h0, 32'h0, 10, rd, lat, rc);
        check("t2_status_busy", rd, 32'h5);
        check("t2_status_model", rd, model_status(rc));
        drain_and_compare("t2");

        // Random traffic against the scoreboard and the status model
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                ws = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) ws[0] = 1'b1;
                xfer(32'h0, ws, $urandom, 400, rd, lat, rc);
                check("rnd_wr_ack", 32'(lat > 0), 32'd1);
            end else if (r < 70) begin
                xfer(32'h4, 4'h0, 32'h0, 10, rd, lat, rc);
                check("rnd_status_lat", 32'(lat), 32'd1);
                check("rnd_status", rd, model_status(rc));
            end else if (r < 80) begin
                xfer(32'h0, 4'h0, 32'h0, 10, rd, lat, rc);
                check("rnd_data_rd", rd, 32'h0);
            end else if (r < 85) begin
                xfer(32'h4, 4'($urandom_range(1, 15)), $urandom, 10, rd, lat, rc);
                check("rnd_status_wr_lat", 32'(lat), 32'd1);
            end else begin
                idle($urandom_range(0, 150));
            end
        end
        drain_and_compare("rnd");

        // Six bytes back to back: FIFO fills, sixth write stalls until the next pop
        base = starts_q.size();
        for (int b = 1; b <= 6; b++) begin
            xfer(32'h0, 4'h1, 32'(b), 400, rd, lat, rc);
            if (b >= 2 && b <= 5) check($sformatf("t3_lat%0d", b), 32'(lat), 32'd1);
        end
        check("t3_stalled", 32'(lat > 50), 32'd1);
        check("t3_ack_after_pop", 32'(rc), 32'(starts_q[base + 1] + 1));
        drain_and_compare("t3");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_gap%0d", i), 32'(starts_q[base + i + 1] - starts_q[base + i]), 32'(FRAME + 1));
        end

        // Not selected: request ignored entirely
        base = starts_q.size();
        bus_if.enable    = 1'b0;
        bus_if.mem_valid = 1'b1;
        bus_if.mem_wstrb = 4'h1;
        bus_if.mem_addr  = 32'h0;
        bus_if.mem_wdata = 32'h77;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_ready === 1'b1) bad++;
        end
        check("t4_no_ready_disabled", 32'(bad), 32'd0);
        bus_if.mem_valid = 1'b0;
        bus_if.enable    = 1'b1;
        idle(3);
        xfer(32'h4, 4'h0, 32'h0, 10, rd, lat, rc);
        check("t4_no_push", rd, 32'h4);
        check("t4_no_frame", 32'(starts_q.size()), 32'(base));

        // Push lands on the same edge the serialiser pops: count stays 1
        xfer(32'h0, 4'h1, 32'h3C, 10, rd, lat, rc);
        xfer(32'h0, 4'h1, 32'hC3, 10, rd, lat, rc);
        s = starts_q[$];
        for (int i = 0; i < 300 && cyc < s + FRAME; i++) @(negedge clk);
        xfer(32'h0, 4'h1, 32'h5A, 10, rd, lat, rc2);
        check("t6_push_edge", 32'(rc2), 32'(s + FRAME + 1));
        xfer(32'h4, 4'h0, 32'h0, 10, rd, lat, rc);
        check("t6_status", rd, 32'h0000_0101);
        check("t6_status_model", rd, model_status(rc));
        check("t6_pop_edge", 32'(starts_q[$]), 32'(s + FRAME + 1));
        drain_and_compare("t6");

        // Reset in data bit 3 with two bytes queued: frame aborted, FIFO flushed
        xfer(32'h0, 4'h1, 32'hF0, 10, rd, lat, rc);
        xfer(32'h0, 4'h1, 32'h11, 10, rd, lat, rc);
        xfer(32'h0, 4'h1, 32'h22, 10, rd, lat, rc);
        s = starts_q[$];
        for (int i = 0; i < 300 && cyc < s + 4 * DIV + DIV / 2; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_tx_after_reset", 32'(tx), 32'd1);
        reset = 1'b0;
        #1;
        rx_q.delete();
        exp_q.delete();
        starts_q.delete();
        push_cnt = 0;
        bad = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check("t5_line_idle", 32'(bad), 32'd0);
        check("t5_no_frames", 32'(starts_q.size()), 32'd0);
        xfer(32'h4, 4'h0, 32'h0, 10, rd, lat, rc);
        check("t5_status", rd, 32'h4);

        check("frame_errors", 32'(frame_err), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
